// File: rtl/jump_target_encoder_pkg.sv
// Shared definitions for the J-type target encoder.
// Holds the opcode constants, error-bit positions, the FIFO entry layout,
// the FIFO occupancy states and the error-detect helper used by the top.
package jump_target_encoder_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // Bit positions inside the 2-bit error vector
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_REGION   = 1;

  localparam int ERR_W   = 2;
  localparam int INDEX_W = 26;
  localparam int ENTRY_W = ERR_W + INDEX_W;

  // One buffered result: error flags alongside the encoded index
  typedef struct packed {
    logic [ERR_W-1:0]   err;
    logic [INDEX_W-1:0] index;
  } jte_entry_t;

  // FIFO occupancy, the only state the block has
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_PARTIAL = 2'b01,
    OCC_FULL    = 2'b10
  } occ_state_t;

  // Error flags for a target: low address bits set, or a target outside
  // the 256 MB region selected by the delay-slot PC.
  function automatic logic [ERR_W-1:0] jte_err(input logic [31:0] target,
                                               input logic [3:0]  pc_hi);
    logic [ERR_W-1:0] e;
    e               = 2'b00;
    e[ERR_MISALIGN] = (target[1:0] != 2'b00);
    e[ERR_REGION]   = (target[31:28] != pc_hi);
    return e;
  endfunction

endpackage

// File: rtl/jte_fifo.sv
// Synchronous FIFO buffering encoded jump results.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data write request and payload (ignored while full)
//   pop             retire the head (ignored while empty)
//   head_data       current head entry, zero while empty
//   head_valid      FIFO holds at least one entry
//   can_push        FIFO is not full; derived from registered state only
module jte_fifo
  import jump_target_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         can_push
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  occ_state_t       occ_s;
  logic             push_s;
  logic             pop_s;

  // Classify occupancy from the registered count
  always_comb begin
    occ_s = OCC_PARTIAL;
    if (count_r == {(PTR_W+1){1'b0}}) begin
      occ_s = OCC_EMPTY;
    end else if (count_r == FULL_CNT) begin
      occ_s = OCC_FULL;
    end else begin
      occ_s = OCC_PARTIAL;
    end
  end

  // Qualify requests and present the head
  always_comb begin
    head_valid = 1'b0;
    can_push   = 1'b1;
    head_data  = {W{1'b0}};
    case (occ_s)
      OCC_EMPTY: begin
        head_valid = 1'b0;
        can_push   = 1'b1;
      end
      OCC_PARTIAL: begin
        head_valid = 1'b1;
        can_push   = 1'b1;
      end
      OCC_FULL: begin
        head_valid = 1'b1;
        can_push   = 1'b0;
      end
      default: begin
        head_valid = 1'b0;
        can_push   = 1'b0;
      end
    endcase
    if (head_valid) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {W{1'b0}};
    end
    push_s = push & can_push;
    pop_s  = pop & head_valid;
  end

  // Storage, pointers and occupancy count; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/jump_target_encoder.sv
// Encodes an absolute jump target into a J/JAL instruction word.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready depends only on FIFO state
//   in_target           absolute jump target
//   in_pc_hi            PC(+4)[31:28] of the jump
//   out_valid/out_ready result handshake on the FIFO head
//   out_index           target[27:2] of the head entry (0 while empty)
//   out_inst            {J_OPCODE, out_index} (0 while empty)
//   out_err             bit0 misaligned, bit1 region mismatch (0 while empty)
//   err_count           saturating count of accepted requests with errors
module jump_target_encoder
  import jump_target_encoder_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         CNT_W    = 16,
  parameter logic [5:0] J_OPCODE = OP_J
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_target,
  input  logic [3:0]       in_pc_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_index,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_count
);

  logic [ERR_W-1:0] err_s;
  jte_entry_t       wr_entry_s;
  jte_entry_t       head_s;
  logic [ENTRY_W-1:0] head_bits_s;
  logic             head_valid_s;
  logic             can_push_s;
  logic             accept_s;
  logic [CNT_W-1:0] err_count_r;

  // Encode the request; erroneous targets are still encoded with low bits dropped
  always_comb begin
    err_s            = jte_err(in_target, in_pc_hi);
    wr_entry_s.err   = err_s;
    wr_entry_s.index = in_target[27:2];
    accept_s         = in_valid & can_push_s;
  end

  jte_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_s),
    .push_data  (wr_entry_s),
    .pop        (out_ready),
    .head_data  (head_bits_s),
    .head_valid (head_valid_s),
    .can_push   (can_push_s)
  );

  // Drive the output payload from the head; zeros while nothing is buffered
  always_comb begin
    head_s    = head_bits_s;
    in_ready  = can_push_s;
    out_valid = head_valid_s;
    if (head_valid_s) begin
      out_index = head_s.index;
      out_err   = head_s.err;
      out_inst  = {J_OPCODE, head_s.index};
    end else begin
      out_index = 26'd0;
      out_err   = 2'b00;
      out_inst  = 32'd0;
    end
  end

  // Count accepted requests carrying any error, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && (err_s != 2'b00) && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;

endmodule
